// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester ports and SDRAM controller port of the arbiter.
// master = requesters plus controller; slave = the arbiter itself.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_wdata;
  logic              ldr_ack;
  logic [7:0]        ldr_rdata;
  logic              ram_cs;
  logic              ram_oe;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              busy;

  modport master (
    output vid_req, vid_addr,
    input  vid_ack, vid_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  ram_cs, ram_oe, ram_we,
    input  ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );

  modport slave (
    input  vid_req, vid_addr,
    output vid_ack, vid_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output ram_cs, ram_oe, ram_we,
    output ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: fixed-window vid/cpu/ldr arbiter for the SDRAM controller.
// SDRAM_ARB_RR_EN: cpu and ldr alternate when both wait; vid stays on top.
module sdram_port_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int ACCESS_CYCLES  = 6,
  parameter int RECOVER_CYCLES = 1
) (
  input logic clk_sys,
  input logic reset,
  sdram_port_arbiter_if.slave bus
);
  localparam int MAX_C = (ACCESS_CYCLES > RECOVER_CYCLES)
                       ? ACCESS_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        sel, grant;
  logic              take, done, cs, ack;
  logic              pick_cpu;
  logic              we_q, we_s;
  logic [ADDR_W-1:0] addr_q, addr_s;
  logic [7:0]        wdata_q, wdata_s;
  logic [7:0]        vid_rd, cpu_rd, ldr_rd;

`ifdef SDRAM_ARB_RR_EN
  logic last_cpu;

  assign pick_cpu = bus.cpu_req & (~bus.ldr_req | ~last_cpu);

  always_ff @(posedge clk_sys) begin
    if (reset)
      last_cpu <= 1'b0;
    else if (take & ~sel[0])
      last_cpu <= sel[1];
  end
`else
  assign pick_cpu = bus.cpu_req;
`endif

  // one-hot winner, vid always first
  assign sel[0] = bus.vid_req;
  assign sel[1] = ~bus.vid_req & pick_cpu;
  assign sel[2] = ~bus.vid_req & ~pick_cpu & bus.ldr_req;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    done    = 1'b0;
    cs      = 1'b0;
    ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|sel) begin
          take    = 1'b1;
          state_n = ACCESS;
          cnt_n   = '0;
        end
      end
      ACCESS: begin
        cs = 1'b1;
        if (cnt == ACC_LAST) begin
          done    = 1'b1;
          state_n = RECOVER;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RECOVER: begin
        ack = (cnt == '0);
        if (cnt == REC_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    addr_s  = '0;
    wdata_s = '0;
    we_s    = 1'b0;
    unique case (1'b1)
      sel[0]: addr_s = bus.vid_addr;
      sel[1]: begin
        addr_s  = bus.cpu_addr;
        wdata_s = bus.cpu_wdata;
        we_s    = bus.cpu_we;
      end
      sel[2]: begin
        addr_s  = bus.ldr_addr;
        wdata_s = bus.ldr_wdata;
        we_s    = bus.ldr_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      vid_rd  <= '0;
      cpu_rd  <= '0;
      ldr_rd  <= '0;
    end else begin
      if (take) begin
        grant   <= sel;
        addr_q  <= addr_s;
        wdata_q <= wdata_s;
        we_q    <= we_s;
      end
      if (done & ~we_q) begin
        unique case (1'b1)
          grant[0]: vid_rd <= bus.ram_rdata;
          grant[1]: cpu_rd <= bus.ram_rdata;
          grant[2]: ldr_rd <= bus.ram_rdata;
          default: ;
        endcase
      end
    end
  end

  assign bus.ram_cs    = cs;
  assign bus.ram_oe    = cs & ~we_q;
  assign bus.ram_we    = cs & we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.vid_ack   = ack & grant[0];
  assign bus.cpu_ack   = ack & grant[1];
  assign bus.ldr_ack   = ack & grant[2];
  assign bus.vid_rdata = vid_rd;
  assign bus.cpu_rdata = cpu_rd;
  assign bus.ldr_rdata = ldr_rd;
endmodule
